// File: rtl/imem_loader.sv
// imem_loader: packs a valid/ready byte stream little-endian into 32-bit words and writes them to consecutive instruction-memory addresses
//   start/base_addr/word_count : load request, sampled in IDLE
//   in_valid/in_ready/in_byte  : byte stream handshake
//   mem_we/mem_addr/mem_wdata  : memory write port, one strobe per word
//   busy/done/checksum         : load status and running word sum
module imem_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, ASSEMBLE, WRITE, DONE} state_t;
  state_t              state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [5:0]          remaining;
  logic [1:0]          byte_idx;
  logic [DATA_W-1:0]   word;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          checksum  <= '0;
          byte_idx  <= '0;
          cur_addr  <= base_addr;
          remaining <= word_count;
          if (word_count != 6'd0) begin
            state    <= ASSEMBLE;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        ASSEMBLE: if (in_valid) begin
          byte_idx                   <= byte_idx + 2'd1;
          word[{byte_idx, 3'b000} +: 8] <= in_byte;
          if (byte_idx == 2'd3) begin
            // the last byte goes straight into the write data, bypassing word
            state     <= WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= {in_byte, word[23:0]};
          end
        end
        WRITE: begin
          mem_we    <= 1'b0;
          checksum  <= checksum + mem_wdata;
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 6'd1;
          byte_idx  <= '0;
          if (remaining == 6'd1) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= ASSEMBLE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader
module tb_imem_loader;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [4:0]  base_addr = 0;
  logic [5:0]  word_count = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  in_byte = 0;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  int          n = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_we = -1;
  logic [36:0] sb[$];
  logic [31:0] words[64];
  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .checksum(checksum)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst) begin
      chk("ready_outside_assemble", 32'(in_ready && (mem_we || !busy)), 0);
      if (mem_we) begin
        last_we = cyc;
        chk("write_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[36:32]));
          chk("wr_data", mem_wdata, e[31:0]);
        end
      end
    end
  end
  task automatic send(input logic [7:0] bt);
    int k = 0;
    in_valid = 1;
    in_byte = bt;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("accept_timeout", 32'(k < 50), 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic load(input logic [4:0] b, input logic [5:0] cnt, input int gap, input bit ms, input int rb);
    logic [31:0] sum = 0;
    logic [4:0]  a;
    int          s, k;
    base_addr = b;
    word_count = cnt;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    s = cyc - 1;
    if (cnt == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_ready", 32'(in_ready), 0);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_sum", checksum, 0);
      @(posedge clk); #1;
      chk("zero_done_pulse", 32'(done), 0);
      return;
    end
    chk("start_ready", 32'(in_ready), 1);
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < int'(cnt); i++) begin
      for (int j = 0; j < 4; j++) begin
        if (rb != 0 && i * 4 + j == rb) begin
          rst = 1;
          @(posedge clk); #1;
          rst = 0;
          chk("rst_ready", 32'(in_ready), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_sum", checksum, 0);
          for (int c = 0; c < 8; c++) begin
            chk("rst_no_done", 32'(done), 0);
            @(posedge clk); #1;
          end
          chk("rst_sb_empty", sb.size(), 0);
          return;
        end
        if (j == 3) begin
          a = b + 5'(i);
          sb.push_back({a, words[i]});
          sum += words[i];
        end
        if (gap != 0) repeat ($urandom_range(0, gap)) begin
          @(posedge clk); #1;
        end
        send(words[i][8*j +: 8]);
        if (ms && i == 0 && j == 1) begin
          base_addr = ~b;
          word_count = 1;
          start = 1;
          @(posedge clk); #1;
          start = 0;
        end
      end
    end
    k = 0;
    while (!done && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("done_seen", 32'(done), 1);
    chk("done_after_we", cyc, last_we + 1);
    if (gap == 0 && !ms) chk("we_latency", last_we, s + 5 * int'(cnt));
    chk("done_busy", 32'(busy), 0);
    chk("checksum", checksum, sum);
    chk("addr_hold", 32'(mem_addr), 32'(5'(b + 5'(cnt - 6'd1))));
    chk("sb_empty", sb.size(), 0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 0);
    chk("checksum_hold", checksum, sum);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 3; c++) begin
      chk("idle_out", {in_ready, mem_we, busy, done}, 0);
      chk("idle_bus", {mem_addr, mem_wdata[26:0]} | checksum, 0);
      @(posedge clk); #1;
    end
    words[0] = 32'h12345678;
    load(5'd0, 6'd1, 0, 0, 0);
    for (int i = 0; i < 4; i++) words[i] = 32'(i + 1);
    load(5'd30, 6'd4, 0, 0, 0);
    chk("wrap_sum", checksum, 32'hA);
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    load(5'd7, 6'd3, 0, 0, 0);
    load(5'd7, 6'd3, 3, 0, 0);
    load(5'd12, 6'd0, 0, 0, 0);
    load(5'd5, 6'd2, 0, 1, 0);
    load(5'd10, 6'd3, 0, 0, 6);
    load(5'd0, 6'd2, 1, 0, 0);
    for (int i = 0; i < 34; i++) words[i] = $urandom;
    load(5'd31, 6'd34, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule
